proc_control_fsm: RTL and testbench

Parametrised control unit for the multicycle simple processor, generalising the earlier combinational control logic. It owns the instruction register and the 2-bit time-step counter and decodes a 3-bit opcode plus two register fields into one-hot register enables and datapath strobes. The instruction set is mv, mvi, add, sub, mvnz plus illegal-opcode reporting. The block sits between the DIN bus and the register file/ALU datapath, and issues one Done pulse per retired instruction.

---
 rtl/proc_control_fsm_if.sv | 34 +++
 rtl/proc_control_fsm.sv | 145 ++++++++++++++
 tb/tb_proc_control_fsm.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proc_control_fsm_if.sv
// Bus bundle between the processor control unit and its DIN source / register-file datapath.
// master = datapath side (drives Run, DIN, Gnz); slave = control unit.
interface proc_control_fsm_if #(
   parameter int REG_ADDR_W = 3
);
   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam int IR_W     = 3 + 2*REG_ADDR_W;

   logic                Run;
   logic [IR_W-1:0]     DIN;
   logic                Gnz;
   logic [IR_W-1:0]     IR;
   logic [1:0]          Tstep;
   logic                IRin;
   logic [NUM_REGS-1:0] Rin;
   logic [NUM_REGS-1:0] Rout;
   logic                Ain;
   logic                Gin;
   logic                Gout;
   logic                DINout;
   logic                AddSub;
   logic                Done;
   logic                Illegal;

   modport master (
      output Run, DIN, Gnz,
      input  IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Illegal
   );

   modport slave (
      input  Run, DIN, Gnz,
      output IR, Tstep, IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done, Illegal
   );
endinterface

// File: rtl/proc_control_fsm.sv
// Control unit for the multicycle simple processor: owns IR and the T0..T3 step counter and
// decodes mv/mvi/add/sub/mvnz into one-hot register enables and datapath strobes.
//
// state | meaning
// T0    | fetch: IR <= DIN when Run is high, otherwise idle
// T1    | execute single-step ops; add/sub: A <= Rx
// T2    | add/sub: G <= A +/- Ry
// T3    | add/sub: Rx <= G
module proc_control_fsm #(
   parameter int REG_ADDR_W = 3
) (
   input logic               Clock,
   input logic               Reset,
   proc_control_fsm_if.slave bus
);
   localparam int NUM_REGS = 2**REG_ADDR_W;
   localparam int IR_W     = 3 + 2*REG_ADDR_W;

   typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b100;

   tstep_e                tstep_q, tstep_d;
   logic [IR_W-1:0]       ir_q, ir_d;
   logic [2:0]            opcode;
   logic [REG_ADDR_W-1:0] rx, ry;
   logic [NUM_REGS-1:0]   rx_oh, ry_oh;
   logic [NUM_REGS-1:0]   rin, rout;
   logic                  irin, ain, gin, gout, dinout, addsub, done, illegal;
   logic                  is_arith;

   assign opcode   = ir_q[2:0];
   assign rx       = ir_q[2+REG_ADDR_W:3];
   assign ry       = ir_q[IR_W-1:3+REG_ADDR_W];
   assign is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);

   always_comb begin
      rx_oh     = '0;
      ry_oh     = '0;
      rx_oh[rx] = 1'b1;
      ry_oh[ry] = 1'b1;
   end

   always_comb begin
      tstep_d = tstep_q;
      ir_d    = ir_q;
      irin    = 1'b0;
      rin     = '0;
      rout    = '0;
      ain     = 1'b0;
      gin     = 1'b0;
      gout    = 1'b0;
      dinout  = 1'b0;
      addsub  = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
      case (tstep_q)
         T0: begin
            irin = bus.Run;
            if (bus.Run) begin
               ir_d    = bus.DIN;
               tstep_d = T1;
            end
         end
         T1: begin
            case (opcode)
               OP_MV: begin
                  rout = ry_oh;
                  rin  = rx_oh;
                  done = 1'b1;
               end
               OP_MVI: begin
                  dinout = 1'b1;
                  rin    = rx_oh;
                  done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout    = rx_oh;
                  ain     = 1'b1;
                  tstep_d = T2;
               end
               OP_MVNZ: begin
                  if (bus.Gnz) begin
                     rout = ry_oh;
                     rin  = rx_oh;
                  end
                  done = 1'b1;
               end
               default: begin
                  done    = 1'b1;
                  illegal = 1'b1;
               end
            endcase
         end
         // A non-arith opcode here means IR was corrupted: drop back to fetch silently.
         T2: begin
            tstep_d = T0;
            if (is_arith) begin
               rout    = ry_oh;
               gin     = 1'b1;
               addsub  = (opcode == OP_SUB);
               tstep_d = T3;
            end
         end
         T3: begin
            tstep_d = T0;
            if (is_arith) begin
               gout = 1'b1;
               rin  = rx_oh;
               done = 1'b1;
            end
         end
         default: tstep_d = T0;
      endcase
      if (done) tstep_d = T0;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         tstep_q <= T0;
         ir_q    <= '0;
      end else begin
         tstep_q <= tstep_d;
         ir_q    <= ir_d;
      end
   end

   // Reset silences every strobe immediately, even though the state only clears on the edge.
   assign bus.IR      = ir_q;
   assign bus.Tstep   = tstep_q;
   assign bus.IRin    = irin    & ~Reset;
   assign bus.Rin     = Reset ? '0 : rin;
   assign bus.Rout    = Reset ? '0 : rout;
   assign bus.Ain     = ain     & ~Reset;
   assign bus.Gin     = gin     & ~Reset;
   assign bus.Gout    = gout    & ~Reset;
   assign bus.DINout  = dinout  & ~Reset;
   assign bus.AddSub  = addsub  & ~Reset;
   assign bus.Done    = done    & ~Reset;
   assign bus.Illegal = illegal & ~Reset;
endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: a 3-bit-field instance (A) and a 2-bit-field instance (B),
// driven from per-scenario step tables through an expected-value queue.
module tb_proc_control_fsm;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   proc_control_fsm_if #(.REG_ADDR_W(3)) if_a ();
   proc_control_fsm_if #(.REG_ADDR_W(2)) if_b ();

   proc_control_fsm #(.REG_ADDR_W(3)) dut_a (.Clock(clk), .Reset(rst), .bus(if_a.slave));
   proc_control_fsm #(.REG_ADDR_W(2)) dut_b (.Clock(clk), .Reset(rst), .bus(if_b.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] tstep;
      logic [8:0] ir;
      logic       irin;
      logic [7:0] rin;
      logic [7:0] rout;
      logic       ain;
      logic       gin;
      logic       gout;
      logic       dinout;
      logic       addsub;
      logic       done;
      logic       illegal;
   } obs_t;

   typedef struct {
      logic       rst;
      logic       run;
      logic [8:0] din;
      logic       gnz;
      obs_t       exp;
   } step_t;

   obs_t       sb_q[$];
   logic [8:0] ir_a;

   function automatic obs_t mk(input logic [1:0] tstep, input logic [8:0] ir, input logic irin,
                               input logic [7:0] rin, input logic [7:0] rout, input logic ain,
                               input logic gin, input logic gout, input logic dinout,
                               input logic addsub, input logic done, input logic illegal);
      obs_t o;
      o = '{tstep, ir, irin, rin, rout, ain, gin, gout, dinout, addsub, done, illegal};
      return o;
   endfunction

   function automatic step_t st(input logic r, input logic run, input logic [8:0] din,
                                input logic gnz, input obs_t e);
      step_t s;
      s.rst = r; s.run = run; s.din = din; s.gnz = gnz; s.exp = e;
      return s;
   endfunction

   function automatic obs_t sample_a();
      return mk(if_a.Tstep, if_a.IR, if_a.IRin, if_a.Rin, if_a.Rout, if_a.Ain, if_a.Gin,
                if_a.Gout, if_a.DINout, if_a.AddSub, if_a.Done, if_a.Illegal);
   endfunction

   function automatic obs_t sample_b();
      return mk(if_b.Tstep, {2'b00, if_b.IR}, if_b.IRin, {4'h0, if_b.Rin}, {4'h0, if_b.Rout},
                if_b.Ain, if_b.Gin, if_b.Gout, if_b.DINout, if_b.AddSub, if_b.Done, if_b.Illegal);
   endfunction

   task automatic drive_a(input step_t s);
      rst = s.rst; if_a.Run = s.run; if_a.DIN = s.din; if_a.Gnz = s.gnz;
      sb_q.push_back(s.exp);
   endtask

   task automatic test_reset();
      step_t steps[$];
      obs_t got, want;
      for (int k = 0; k < 3; k++)
         steps.push_back(st(1, 1, 9'o010, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, 9'o010, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'o000, 0, mk(1, 9'o010, 0, 8'h02, 8'h01, 0, 0, 0, 0, 0, 1, 0)));
      steps.push_back(st(0, 0, 9'o000, 0, mk(0, 9'o010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = 9'o010;
   endtask

   task automatic test_mv();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins = 9'b010_111_000;
      steps.push_back(st(0, 1, ins, 0, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 1, mk(1, ins, 0, 8'h80, 8'h04, 0, 0, 0, 0, 0, 1, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL mv step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = ins;
   endtask

   task automatic test_mvi();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins = 9'b000_101_001;
      steps.push_back(st(0, 1, ins, 0, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h1AB, 0, mk(1, ins, 0, 8'h20, 0, 0, 0, 0, 1, 0, 1, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL mvi step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = ins;
   endtask

   task automatic test_arith(input logic [8:0] ins, input logic [7:0] rx_oh,
                             input logic [7:0] ry_oh, input logic sub);
      step_t steps[$];
      obs_t got, want;
      steps.push_back(st(0, 1, ins, 0, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, 9'h1FF, 1, mk(1, ins, 0, 0, rx_oh, 1, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, 9'h1FF, 1, mk(2, ins, 0, 0, ry_oh, 0, 1, 0, 0, sub, 0, 0)));
      steps.push_back(st(0, 1, 9'h1FF, 1, mk(3, ins, 0, rx_oh, 0, 0, 0, 1, 0, 0, 1, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL arith %h step %0d: got %h expected %h", ins, i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = ins;
   endtask

   task automatic test_mvnz();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins = 9'b100_010_100;
      steps.push_back(st(0, 1, ins, 1, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(1, ins, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)));
      steps.push_back(st(0, 1, ins, 0, mk(0, ins, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 1, mk(1, ins, 0, 8'h04, 8'h10, 0, 0, 0, 0, 0, 1, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL mvnz step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = ins;
   endtask

   task automatic test_illegal();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins;
      logic [8:0] prev = ir_a;
      for (int op = 5; op < 8; op++) begin
         ins = {3'd2, 3'd1, 3'(op)};
         steps.push_back(st(0, 1, ins, 1, mk(0, prev, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
         steps.push_back(st(0, 0, 9'h0, 1, mk(1, ins, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
         prev = ins;
      end
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL illegal step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = prev;
   endtask

   task automatic test_back_to_back();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] i1 = 9'b001_011_000;
      logic [8:0] i2 = 9'b001_000_010;
      steps.push_back(st(0, 1, i1, 0, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, i2, 0, mk(1, i1, 0, 8'h08, 8'h02, 0, 0, 0, 0, 0, 1, 0)));
      steps.push_back(st(0, 1, i2, 0, mk(0, i1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, 9'h0, 0, mk(1, i2, 0, 0, 8'h01, 1, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 1, 9'h0, 0, mk(2, i2, 0, 0, 8'h02, 0, 1, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(3, i2, 0, 8'h01, 0, 0, 0, 1, 0, 0, 1, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL back_to_back step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = i2;
   endtask

   task automatic test_reset_mid();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins = 9'b010_001_010;
      steps.push_back(st(0, 1, ins, 0, mk(0, ir_a, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(1, ins, 0, 0, 8'h02, 1, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(1, 1, 9'h0, 0, mk(2, ins, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      foreach (steps[i]) begin
         drive_a(steps[i]);
         @(negedge clk);
         got = sample_a(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL reset_mid step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      ir_a = 9'h0;
   endtask

   task automatic test_sub_narrow();
      step_t steps[$];
      obs_t got, want;
      logic [8:0] ins = {2'b00, 7'b10_11_011};
      steps.push_back(st(0, 1, ins, 0, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(1, ins, 0, 0, 8'h08, 1, 0, 0, 0, 0, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(2, ins, 0, 0, 8'h04, 0, 1, 0, 0, 1, 0, 0)));
      steps.push_back(st(0, 0, 9'h0, 0, mk(3, ins, 0, 8'h08, 0, 0, 0, 1, 0, 0, 1, 0)));
      if_a.Run = 1'b0;
      foreach (steps[i]) begin
         rst = steps[i].rst; if_b.Run = steps[i].run;
         if_b.DIN = steps[i].din[6:0]; if_b.Gnz = steps[i].gnz;
         sb_q.push_back(steps[i].exp);
         @(negedge clk);
         got = sample_b(); want = sb_q.pop_front(); vectors++;
         if (got !== want) begin
            miscompares++;
            $display("FAIL sub_narrow step %0d: got %h expected %h", i, got, want);
         end
         @(posedge clk); #1;
      end
      if_b.Run = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vectors     = 0;
      miscompares = 0;
      ir_a        = 9'h0;
      rst         = 1'b1;
      if_a.Run = 1'b0; if_a.DIN = '0; if_a.Gnz = 1'b0;
      if_b.Run = 1'b0; if_b.DIN = '0; if_b.Gnz = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_mv();
      test_mvi();
      test_arith(9'b110_011_011, 8'h08, 8'h40, 1'b1);
      test_arith(9'b010_010_010, 8'h04, 8'h04, 1'b0);
      test_mvnz();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      test_sub_narrow();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
